interrupt_requester: RTL

Producer-side controller that raises and clears the accelerator's completion interrupt in the interrupt register through its write interface.
- Converts single-cycle layer-done pulses from the compute pipeline into register write transactions.
- Queues done events that arrive while an interrupt is outstanding.
- Completes a CPU acknowledge handshake, then enforces a hold-off gap before the next raise.

---
 rtl/interrupt_requester.sv | 123 ++++++++++++
 1 files changed

// File: rtl/interrupt_requester.sv
// interrupt_requester: turns layer-done pulses into raise/clear writes to the
// interrupt register, queues events while an interrupt is outstanding, and
// enforces a hold-off gap after each clear.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | nothing outstanding; leaves as soon as an event is queued
// RAISE    | one-cycle raise write (data=1); consumes one queued event
// WAIT_ACK | interrupt asserted, waiting for the CPU acknowledge
// CLEAR    | one-cycle clear write (data=0)
// HOLDOFF  | HOLDOFF_CYCLES idle cycles before the next raise
module interrupt_requester #(
    parameter int CNT_W          = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             done_pulse,
    input  logic             irq_ack,
    output logic             write_signal,
    output logic             write_data,
    output logic             irq_pending,
    output logic [CNT_W-1:0] pending_count,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAISE    = 3'd1,
        WAIT_ACK = 3'd2,
        CLEAR    = 3'd3,
        HOLDOFF  = 3'd4
    } state_t;

    localparam int              HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = (HOLDOFF_CYCLES > 0) ? HO_W'(HOLDOFF_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [HO_W-1:0]  hold_q, hold_d;

    logic inc;
    logic dec;

    assign inc = done_pulse & enable;
    assign dec = (state_q == RAISE);

    // State, counter, overflow and hold-off registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (count_q != '0) state_d = RAISE;
            RAISE:    state_d = WAIT_ACK;
            WAIT_ACK: if (irq_ack) state_d = CLEAR;
            CLEAR:    state_d = (HOLDOFF_CYCLES > 0) ? HOLDOFF : IDLE;
            HOLDOFF:  if (hold_q == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Pending-event counter; RAISE is only entered with a nonzero count, so
    // the decrement never underflows. A lost increment sets sticky overflow.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc && !dec) begin
            if (count_q == CNT_MAX) ovf_d   = 1'b1;
            else                    count_d = count_q + 1'b1;
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    // Hold-off down-counter: loaded in CLEAR, leaves HOLDOFF at terminal count
    always_comb begin
        hold_d = hold_q;
        if (state_q == CLEAR)
            hold_d = HO_LOAD;
        else if (state_q == HOLDOFF && hold_q != '0)
            hold_d = hold_q - 1'b1;
    end

    // Moore output decode
    always_comb begin
        write_signal = 1'b0;
        write_data   = 1'b0;
        irq_pending  = 1'b0;
        busy         = (state_q != IDLE);
        case (state_q)
            RAISE: begin
                write_signal = 1'b1;
                write_data   = 1'b1;
                irq_pending  = 1'b1;
            end
            WAIT_ACK: irq_pending  = 1'b1;
            CLEAR:    write_signal = 1'b1;
            default: ;
        endcase
    end

    assign pending_count = count_q;
    assign overflow      = ovf_q;

endmodule
